// File: rtl/soc_gpio_pkg.sv
// Shared definitions for the SoC GPIO controller: register map and counter widths.
package soc_gpio_pkg;

    // Word register indices on the core data bus
    typedef enum logic [3:0] {
        GPIO_ODR     = 4'd0,
        GPIO_ODR_SET = 4'd1,
        GPIO_ODR_CLR = 4'd2,
        GPIO_OER     = 4'd3,
        GPIO_IDR     = 4'd4,
        GPIO_RISE_EN = 4'd5,
        GPIO_FALL_EN = 4'd6,
        GPIO_ISR     = 4'd7,
        GPIO_FILT_EN = 4'd8,
        GPIO_PRESC   = 4'd9
    } gpio_reg_e;

    localparam int unsigned PRESC_W            = 16;
    localparam int unsigned FILTER_LEN_DEFAULT = 4;
    localparam int unsigned FILTER_CNT_W       = $clog2(FILTER_LEN_DEFAULT);

    // Counter width for an arbitrary filter length; never narrower than one bit
    function automatic int unsigned filter_cnt_w(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/soc_gpio_in_filter.sv
// One GPIO input pin: synchroniser, optional glitch filter and the resulting level flop.
module soc_gpio_in_filter
    import soc_gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic filt_en,
    input  logic tick,
    output logic level
);

    localparam int unsigned CNT_W = filter_cnt_w(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   sync;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign level = level_q;

    // Shift the asynchronous pad input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Filter: accept a new level only after FILTER_LEN consecutive differing ticks
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!filt_en) begin
            level_d = sync;
            cnt_d   = '0;
        end else if (tick) begin
            if (sync == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                level_d = sync;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter counter and accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/soc_gpio_ctrl.sv
// GPIO controller top: register file, prescaler, per-pin input path, edge detect and interrupts.
module soc_gpio_ctrl
    import soc_gpio_pkg::*;
#(
    parameter int unsigned N_PINS      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        addr,
    input  logic [31:0]       wdata,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic [N_PINS-1:0] gpio_dout,
    output logic [N_PINS-1:0] gpio_oe,
    input  logic [N_PINS-1:0] gpio_din,
    output logic              irq
);

    logic [N_PINS-1:0]  odr_q, odr_d;
    logic [N_PINS-1:0]  oer_q, oer_d;
    logic [N_PINS-1:0]  rise_en_q, rise_en_d;
    logic [N_PINS-1:0]  fall_en_q, fall_en_d;
    logic [N_PINS-1:0]  filt_en_q, filt_en_d;
    logic [N_PINS-1:0]  isr_q, isr_d;
    logic [N_PINS-1:0]  isr_clr;
    logic [N_PINS-1:0]  level, prev_q;
    logic [N_PINS-1:0]  rise, fall;
    logic [N_PINS-1:0]  wdata_pin;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               tick;
    logic               wr, rd, presc_wr;
    logic [31:0]        rd_mux;
    logic [31:0]        rdata_q;
    logic               rvalid_q;

    assign wr        = req & we;
    assign rd        = req & ~we;
    assign wdata_pin = wdata[N_PINS-1:0];
    assign presc_wr  = wr && (addr == GPIO_PRESC);

    assign gpio_dout = odr_q;
    assign gpio_oe   = oer_q;
    assign irq       = |isr_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

    // Per-pin input path sharing the prescaler tick
    for (genvar i = 0; i < N_PINS; i++) begin : g_pin
        soc_gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_in_filter (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (gpio_din[i]),
            .filt_en (filt_en_q[i]),
            .tick    (tick),
            .level   (level[i])
        );
    end

    // Prescaler: down counter, tick at zero, reload from PRESC (immediately on a PRESC write)
    always_comb begin
        tick        = (presc_cnt_q == '0);
        presc_cnt_d = presc_cnt_q - 1'b1;
        if (presc_wr) begin
            presc_cnt_d = wdata[PRESC_W-1:0];
        end else if (tick) begin
            presc_cnt_d = presc_q;
        end
    end

    assign rise = level & ~prev_q & rise_en_q;
    assign fall = ~level & prev_q & fall_en_q;

    // Register writes; an edge on a bit being cleared keeps that ISR bit set
    always_comb begin
        odr_d     = odr_q;
        oer_d     = oer_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        filt_en_d = filt_en_q;
        presc_d   = presc_q;
        isr_clr   = '0;
        if (wr) begin
            case (addr)
                GPIO_ODR:     odr_d     = wdata_pin;
                GPIO_ODR_SET: odr_d     = odr_q | wdata_pin;
                GPIO_ODR_CLR: odr_d     = odr_q & ~wdata_pin;
                GPIO_OER:     oer_d     = wdata_pin;
                GPIO_RISE_EN: rise_en_d = wdata_pin;
                GPIO_FALL_EN: fall_en_d = wdata_pin;
                GPIO_ISR:     isr_clr   = wdata_pin;
                GPIO_FILT_EN: filt_en_d = wdata_pin;
                GPIO_PRESC:   presc_d   = wdata[PRESC_W-1:0];
                default:      ;
            endcase
        end
        isr_d = (isr_q & ~isr_clr) | rise | fall;
    end

    // Read mux; write-only, unmapped and unused upper bits read as zero
    always_comb begin
        rd_mux = '0;
        case (addr)
            GPIO_ODR:     rd_mux = 32'(odr_q);
            GPIO_OER:     rd_mux = 32'(oer_q);
            GPIO_IDR:     rd_mux = 32'(level);
            GPIO_RISE_EN: rd_mux = 32'(rise_en_q);
            GPIO_FALL_EN: rd_mux = 32'(fall_en_q);
            GPIO_ISR:     rd_mux = 32'(isr_q);
            GPIO_FILT_EN: rd_mux = 32'(filt_en_q);
            GPIO_PRESC:   rd_mux = 32'(presc_q);
            default:      rd_mux = '0;
        endcase
    end

    // Control/status registers, prescaler and edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odr_q       <= '0;
            oer_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            filt_en_q   <= '0;
            isr_q       <= '0;
            prev_q      <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
        end else begin
            odr_q       <= odr_d;
            oer_q       <= oer_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            filt_en_q   <= filt_en_d;
            isr_q       <= isr_d;
            prev_q      <= level;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    // Registered read response, one cycle after the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd;
            if (rd) begin
                rdata_q <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_soc_gpio_ctrl.sv
// Directed, table-driven bench for soc_gpio_ctrl (32-pin and 8-pin instances).
module tb_soc_gpio_ctrl;

    logic        clk;
    logic        rst_n;

    logic        req, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] dout, oe, din;
    logic        irq;

    logic        req8, we8;
    logic [3:0]  addr8;
    logic [31:0] wdata8;
    logic        rvalid8;
    logic [31:0] rdata8;
    logic [7:0]  dout8, oe8, din8;
    logic        irq8;

    int n_tests = 0;
    int n_fail  = 0;

    soc_gpio_ctrl #(.N_PINS(32), .SYNC_STAGES(2), .FILTER_LEN(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .gpio_dout (dout),
        .gpio_oe   (oe),
        .gpio_din  (din),
        .irq       (irq)
    );

    soc_gpio_ctrl #(.N_PINS(8), .SYNC_STAGES(2), .FILTER_LEN(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req8),
        .we        (we8),
        .addr      (addr8),
        .wdata     (wdata8),
        .rvalid    (rvalid8),
        .rdata     (rdata8),
        .gpio_dout (dout8),
        .gpio_oe   (oe8),
        .gpio_din  (din8),
        .irq       (irq8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel == 0) begin
            req = 1'b1; we = 1'b1; addr = a; wdata = d;
        end else begin
            req8 = 1'b1; we8 = 1'b1; addr8 = a; wdata8 = d;
        end
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; req8 = 1'b0; we8 = 1'b0;
    endtask

    task automatic rd(input int sel, input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        if (sel == 0) begin
            req = 1'b1; we = 1'b0; addr = a;
        end else begin
            req8 = 1'b1; we8 = 1'b0; addr8 = a;
        end
        @(posedge clk);
        #1;
        req = 1'b0; req8 = 1'b0;
        check("rvalid_on_read", 32'((sel == 0) ? rvalid : rvalid8), 32'd1);
        d = (sel == 0) ? rdata : rdata8;
    endtask

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] r;

        vecs[0]  = '{4'd0, 32'h0000_00F0, 4'd0, 32'h0000_00F0};
        vecs[1]  = '{4'd1, 32'h0000_0001, 4'd0, 32'h0000_00F1};
        vecs[2]  = '{4'd2, 32'h0000_0010, 4'd0, 32'h0000_00E1};
        vecs[3]  = '{4'd2, 32'hFFFF_FF00, 4'd2, 32'h0000_0000};
        vecs[4]  = '{4'd3, 32'hA5A5_0000, 4'd3, 32'hA5A5_0000};
        vecs[5]  = '{4'd4, 32'h0000_FFFF, 4'd4, 32'h0000_0000};
        vecs[6]  = '{4'd9, 32'h1234_5678, 4'd9, 32'h0000_5678};
        vecs[7]  = '{4'd9, 32'h0000_0000, 4'd9, 32'h0000_0000};
        vecs[8]  = '{4'd12, 32'hDEAD_BEEF, 4'd12, 32'h0000_0000};
        vecs[9]  = '{4'd8, 32'h0F0F_0F0F, 4'd8, 32'h0F0F_0F0F};
        vecs[10] = '{4'd8, 32'h0000_0000, 4'd8, 32'h0000_0000};
        vecs[11] = '{4'd6, 32'h8000_0001, 4'd6, 32'h8000_0001};
        vecs[12] = '{4'd6, 32'h0000_0000, 4'd0, 32'h0000_00E1};
        vecs[13] = '{4'd5, 32'h0000_0004, 4'd5, 32'h0000_0004};

        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; din = '0;
        req8 = 1'b0; we8 = 1'b0; addr8 = '0; wdata8 = '0; din8 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_dout", dout, 32'h0);
        check("reset_oe", oe, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rvalid", 32'(rvalid), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_dout8", 32'(dout8), 32'h0);

        // Register table
        for (int i = 0; i < 14; i++) begin
            wr(0, vecs[i].waddr, vecs[i].wdata);
            if (i == 0) check("rvalid_on_write", 32'(rvalid), 32'h0);
            rd(0, vecs[i].raddr, r);
            check($sformatf("vec%0d", i), r, vecs[i].exp);
            if (i == 0) begin
                @(posedge clk);
                #1;
                check("rvalid_drop", 32'(rvalid), 32'h0);
            end
        end
        check("dout_e1", dout, 32'h0000_00E1);
        check("oe_value", oe, 32'hA5A5_0000);

        // Rising edge on pin 2: irq after SYNC_STAGES+2 cycles, W1C clears it
        @(negedge clk);
        din[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("irq_early", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("irq_rise", 32'(irq), 32'h1);
        rd(0, 4'd7, r);
        check("isr_rise", r, 32'h4);
        wr(0, 4'd7, 32'h4);
        check("irq_cleared", 32'(irq), 32'h0);
        rd(0, 4'd7, r);
        check("isr_cleared", r, 32'h0);

        // W1C on bit 0 in the same cycle as a falling edge on pin 0: edge wins
        @(negedge clk);
        din[0] = 1'b1;
        repeat (6) @(negedge clk);
        wr(0, 4'd6, 32'h1);
        @(negedge clk);
        din[0] = 1'b0;
        repeat (3) @(posedge clk);
        wr(0, 4'd7, 32'h1);
        rd(0, 4'd7, r);
        check("isr_collision", r, 32'h1);
        wr(0, 4'd6, 32'h0);
        rd(0, 4'd7, r);
        check("isr_kept_after_disable", r, 32'h1);
        wr(0, 4'd7, 32'h1);
        check("irq_after_clear", 32'(irq), 32'h0);

        // Glitch filter with tick every cycle
        wr(0, 4'd8, 32'h8);
        @(negedge clk);
        din[3] = 1'b1;
        repeat (3) @(negedge clk);
        din[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd(0, 4'd4, r);
        check("filt_short_pulse", r, 32'h4);
        din[3] = 1'b1;
        repeat (10) @(negedge clk);
        rd(0, 4'd4, r);
        check("filt_long_pulse", r, 32'hC);
        din[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd(0, 4'd4, r);
        check("filt_release", r, 32'h4);

        // Prescaled filter: 4 ticks of 10 cycles before the level moves
        wr(0, 4'd9, 32'd9);
        wr(0, 4'd8, 32'h1);
        @(negedge clk);
        din[0] = 1'b1;
        repeat (20) @(negedge clk);
        rd(0, 4'd4, r);
        check("presc_not_yet", r, 32'h4);
        repeat (30) @(negedge clk);
        rd(0, 4'd4, r);
        check("presc_accepted", r, 32'h5);

        // 8-pin instance: upper bits discarded
        wr(1, 4'd0, 32'hFFFF_FFFF);
        rd(1, 4'd0, r);
        check("n8_odr", r, 32'hFF);
        check("n8_dout", 32'(dout8), 32'hFF);
        wr(1, 4'd3, 32'hFFFF_FFFF);
        wr(1, 4'd5, 32'h2);
        @(negedge clk);
        din8[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("n8_irq", 32'(irq8), 32'h1);

        // Asynchronous reset in the middle of a filter run
        wr(1, 4'd9, 32'd9);
        wr(1, 4'd8, 32'h1);
        @(negedge clk);
        din8[0] = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dout8", 32'(dout8), 32'h0);
        check("async_oe8", 32'(oe8), 32'h0);
        check("async_irq8", 32'(irq8), 32'h0);
        check("async_dout", dout, 32'h0);
        check("async_oe", oe, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        rd(1, 4'd4, r);
        check("n8_idr_after_reset", r, 32'h3);
        check("n8_irq_after_reset", 32'(irq8), 32'h0);
        rd(0, 4'd0, r);
        check("odr_after_reset", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
